// File: rtl/traffic_phase_fsm.sv
// Six-phase traffic light sequencer that loads the interval Timer and gates side green on a latched demand.
// Optional maintenance flash mode is compiled in when TLC_FLASH_EN is defined.
module traffic_phase_fsm #(
   parameter int unsigned MAIN_GREEN_T = 8,
   parameter int unsigned SIDE_GREEN_T = 6,
   parameter int unsigned YELLOW_T     = 3,
   parameter int unsigned ALL_RED_T    = 1
) (
   input  logic       clkin,
   input  logic       rst_n,
   input  logic       expired,
   input  logic       sensor_in,
   input  logic       seconds_enabled,
   input  logic       flash_mode,
   output logic [3:0] value,
   output logic       start_timer,
   output logic [2:0] main_lights,
   output logic [2:0] side_lights,
   output logic       side_req
);

   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_G = 3'b001;

   typedef enum logic [2:0] {
      MAIN_GREEN,
      MAIN_YELLOW,
      ALL_RED_A,
      SIDE_GREEN,
      SIDE_YELLOW,
      ALL_RED_B
`ifdef TLC_FLASH_EN
      , FLASH
`endif
   } phase_t;

   // step names the action taken at the next edge; WAIT is main green held for demand.
   typedef enum logic [1:0] {LOAD, SETTLE, RUN, WAIT} step_t;

   function automatic logic [3:0] clip(input int unsigned t);
      if (t == 0)      return 4'd1;
      else if (t > 15) return 4'd15;
      else             return 4'(t);
   endfunction

   function automatic logic [3:0] phase_value(input phase_t p);
      case (p)
         MAIN_GREEN:               return clip(MAIN_GREEN_T);
         SIDE_GREEN:               return clip(SIDE_GREEN_T);
         MAIN_YELLOW, SIDE_YELLOW: return clip(YELLOW_T);
         default:                  return clip(ALL_RED_T);
      endcase
   endfunction

   function automatic phase_t succ(input phase_t p);
      case (p)
         MAIN_GREEN:  return MAIN_YELLOW;
         MAIN_YELLOW: return ALL_RED_A;
         ALL_RED_A:   return SIDE_GREEN;
         SIDE_GREEN:  return SIDE_YELLOW;
         SIDE_YELLOW: return ALL_RED_B;
         default:     return MAIN_GREEN;
      endcase
   endfunction

   phase_t     phase, phase_n;
   step_t      step, step_n;
   logic [3:0] value_n;
   logic       start_n, req_n, load;
   logic [2:0] main_n, side_n;

   always_ff @(posedge clkin) begin
      if (!rst_n) begin
         phase       <= ALL_RED_B;
         step        <= LOAD;
         value       <= clip(ALL_RED_T);
         start_timer <= 1'b0;
         main_lights <= LAMP_R;
         side_lights <= LAMP_R;
         side_req    <= 1'b0;
      end else begin
         phase       <= phase_n;
         step        <= step_n;
         value       <= value_n;
         start_timer <= start_n;
         main_lights <= main_n;
         side_lights <= side_n;
         side_req    <= req_n;
      end
   end

   always_comb begin
      phase_n = phase;
      step_n  = step;
      value_n = value;
      start_n = 1'b0;
      main_n  = main_lights;
      side_n  = side_lights;
      req_n   = side_req | sensor_in;
      load    = 1'b0;

      case (step)
         LOAD:   load = 1'b1;
         SETTLE: step_n = RUN;
         RUN: begin
            if (expired) begin
               if (phase != MAIN_GREEN || side_req) begin
                  phase_n = succ(phase);
                  load    = 1'b1;
               end else begin
                  step_n = WAIT;
               end
            end
         end
         WAIT: begin
            if (side_req) begin
               phase_n = succ(phase);
               load    = 1'b1;
            end
         end
      endcase

      if (load) begin
         step_n  = SETTLE;
         start_n = 1'b1;
         value_n = phase_value(phase_n);
         main_n  = (phase_n == MAIN_GREEN)  ? LAMP_G :
                   (phase_n == MAIN_YELLOW) ? LAMP_Y : LAMP_R;
         side_n  = (phase_n == SIDE_GREEN)  ? LAMP_G :
                   (phase_n == SIDE_YELLOW) ? LAMP_Y : LAMP_R;
         // A demand on the side-green entry edge survives and is served next cycle.
         if (phase_n == SIDE_GREEN && !sensor_in)
            req_n = 1'b0;
      end

`ifdef TLC_FLASH_EN
      if (flash_mode) begin
         phase_n = FLASH;
         step_n  = LOAD;
         start_n = 1'b0;
         req_n   = side_req | sensor_in;
         value_n = value;
         if (phase != FLASH) begin
            main_n = LAMP_Y;
            side_n = LAMP_R;
         end else if (seconds_enabled) begin
            main_n = main_lights ^ LAMP_Y;
            side_n = side_lights ^ LAMP_R;
         end else begin
            main_n = main_lights;
            side_n = side_lights;
         end
      end else if (phase == FLASH) begin
         phase_n = ALL_RED_B;
         step_n  = LOAD;
         start_n = 1'b0;
         req_n   = side_req | sensor_in;
         value_n = clip(ALL_RED_T);
         main_n  = LAMP_R;
         side_n  = LAMP_R;
      end
`endif
   end

`ifndef TLC_FLASH_EN
   logic unused_flash;
   assign unused_flash = flash_mode ^ seconds_enabled;
`endif

endmodule

// File: tb/tb_traffic_phase_fsm.sv
// Directed bench for traffic_phase_fsm: cycle-level phase model plus literal spot checks.
// Flash-mode vectors are included when TLC_FLASH_EN is defined.
module tb_traffic_phase_fsm;

   localparam int MG = 8, SG = 6, YT = 3, AR = 1;
   localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, O = 3'b000;

   logic       clkin = 1'b0;
   logic       rst_n, expired, sensor_in, seconds_enabled, flash_mode;
   logic [3:0] value;
   logic       start_timer, side_req;
   logic [2:0] main_lights, side_lights;

   traffic_phase_fsm #(
      .MAIN_GREEN_T(MG), .SIDE_GREEN_T(SG), .YELLOW_T(YT), .ALL_RED_T(AR)
   ) dut (
      .clkin(clkin), .rst_n(rst_n), .expired(expired), .sensor_in(sensor_in),
      .seconds_enabled(seconds_enabled), .flash_mode(flash_mode),
      .value(value), .start_timer(start_timer), .main_lights(main_lights),
      .side_lights(side_lights), .side_req(side_req)
   );

   // clock / reset
   always #5 clkin = ~clkin;

   // Phase i of the cycle 0..5: MG, MY, AR_A, SG, SY, AR_B.
   function automatic logic [3:0] dur(input int p);
      int t;
      case (p)
         0: t = MG;
         3: t = SG;
         1, 4: t = YT;
         default: t = AR;
      endcase
      return (t < 1) ? 4'd1 : 4'(t);
   endfunction

   function automatic logic [5:0] lamps(input int p);
      logic [2:0] m, s;
      m = (p == 0) ? G : (p == 1) ? Y : R;
      s = (p == 3) ? G : (p == 4) ? Y : R;
      return {m, s};
   endfunction

   function automatic logic [11:0] vec(input logic st, input logic [3:0] v,
                                       input logic [2:0] m, input logic [2:0] s,
                                       input logic r);
      return {st, v, m, s, r};
   endfunction

   // behavioural model: phase index, edges since the last load, demand latch
   int         m_phase, m_since;
   bit         m_pend, m_hold, m_req, m_valid = 1'b0, m_flash;
   logic       e_start;
   logic [3:0] e_value;
   logic [2:0] e_main, e_side;

   always @(posedge clkin) begin
      bit go;
      if (!rst_n) begin
         m_phase = 5; m_pend = 1; m_hold = 0; m_req = 0; m_since = 0; m_flash = 0;
         e_start = 0; e_value = dur(5); e_main = R; e_side = R; m_valid = 1;
      end
`ifdef TLC_FLASH_EN
      else if (flash_mode) begin
         if (!m_flash) begin
            m_flash = 1; e_main = Y; e_side = R;
         end else if (seconds_enabled) begin
            e_main = (e_main == Y) ? O : Y;
            e_side = (e_side == R) ? O : R;
         end
         e_start = 0;
         m_req = m_req | sensor_in;
      end else if (m_flash) begin
         m_flash = 0; m_phase = 5; m_pend = 1; m_hold = 0;
         e_start = 0; e_value = dur(5); e_main = R; e_side = R;
         m_req = m_req | sensor_in;
      end
`endif
      else begin
         go = 0;
         if (m_pend) go = 1;
         else begin
            m_since++;
            if (m_since >= 2) begin
               if (m_phase == 0) begin
                  go = (expired || m_hold) && m_req;
                  if (expired && !m_req) m_hold = 1;
               end else go = expired;
            end
         end
         e_start = 0;
         if (go) begin
            if (!m_pend) m_phase = (m_phase + 1) % 6;
            m_pend = 0; m_since = 0; m_hold = 0;
            e_start = 1;
            e_value = dur(m_phase);
            {e_main, e_side} = lamps(m_phase);
            if (m_phase == 3) m_req = 0;
         end
         if (sensor_in) m_req = 1;
      end
   end

   // scoreboard: literal expectations queued by the driver, checked at the next falling edge
   logic [11:0] exp_q[$];
   string       name_q[$];
   int          vectors = 0, miscompares = 0, cyc = 0;

   always @(negedge clkin) begin
      logic [11:0] act, mdl, e;
      string       n;
      cyc++;
      if (m_valid) begin
         act = {start_timer, value, main_lights, side_lights, side_req};
         mdl = {e_start, e_value, e_main, e_side, m_req};
         vectors++;
         if (act !== mdl) begin
            miscompares++;
            $display("FAIL model cycle %0d: dut=%03h model=%03h", cyc, act, mdl);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            vectors++;
            if (act !== e) begin
               miscompares++;
               $display("FAIL %s: dut=%03h expected=%03h", n, act, e);
            end
         end
      end
   end

   // driver tasks
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clkin);
         #1;
      end
   endtask

   task automatic lit(input string n, input logic [11:0] e);
      exp_q.push_back(e);
      name_q.push_back(n);
   endtask

   initial begin
      rst_n = 0; expired = 0; sensor_in = 0; seconds_enabled = 0; flash_mode = 0;
      tick(2);
      lit("reset", vec(0, 1, R, R, 0));
      rst_n = 1;
      tick(); lit("first_load", vec(1, 1, R, R, 0));
      tick(); lit("settle", vec(0, 1, R, R, 0));
      tick(4); lit("no_reload", vec(0, 1, R, R, 0));

      expired = 1; tick(); expired = 0;
      lit("main_green_load", vec(1, 8, G, R, 0));
      tick(2);
      expired = 1; tick(3);
      lit("main_hold", vec(0, 8, G, R, 0));
      expired = 0; tick(2);
      sensor_in = 1; tick(); sensor_in = 0;
      lit("req_latched", vec(0, 8, G, R, 1));
      tick(); lit("main_yellow", vec(1, 3, Y, R, 1));

      expired = 1;
      tick(); lit("yellow_settle", vec(0, 3, Y, R, 1));
      tick(); lit("all_red_a", vec(1, 1, R, R, 1));
      tick();
      sensor_in = 1; tick(); sensor_in = 0;
      lit("side_green_req_kept", vec(1, 6, R, G, 1));
      tick(2); lit("side_yellow", vec(1, 3, R, Y, 1));
      tick(2); lit("all_red_b", vec(1, 1, R, R, 1));
      tick(2); lit("main_green_again", vec(1, 8, G, R, 1));
      tick(2); lit("yellow_direct", vec(1, 3, Y, R, 1));
      tick(4); lit("side_green_clear", vec(1, 6, R, G, 0));
      tick();
      rst_n = 0; expired = 0;
      tick(); lit("reset_mid_side", vec(0, 1, R, R, 0));
      rst_n = 1;
      tick(); lit("reload_after_reset", vec(1, 1, R, R, 0));

`ifdef TLC_FLASH_EN
      flash_mode = 1;
      tick(); lit("flash_entry", vec(0, 1, Y, R, 0));
      seconds_enabled = 1; tick(); seconds_enabled = 0;
      lit("flash_off", vec(0, 1, O, O, 0));
      tick(); lit("flash_steady", vec(0, 1, O, O, 0));
      seconds_enabled = 1; tick(); seconds_enabled = 0;
      lit("flash_on", vec(0, 1, Y, R, 0));
      flash_mode = 0;
      tick(); lit("flash_exit", vec(0, 1, R, R, 0));
      tick(); lit("flash_reload", vec(1, 1, R, R, 0));
      flash_mode = 1; rst_n = 0;
      tick(); lit("reset_over_flash", vec(0, 1, R, R, 0));
      flash_mode = 0; rst_n = 1;
`endif

      tick(6);
      @(negedge clkin);
      #1;
      if (exp_q.size() != 0) begin
         $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
         miscompares++;
      end
      // final report
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
